// File: rtl/rom_scan_reader.sv
// rom_scan_reader: raster-scans one ROM image segment per start pulse and
// streams the returned pixels (with sof/eol/eof tags) over valid/ready.
// ROM latency is absorbed by a tag pipeline, and the output FIFO is
// protected by a credit rule (occupancy + in-flight < FIFO_DEPTH).
// Optional build macro ROM_SCAN_ONES_COUNT_EN adds the ones_count port,
// which counts handed-off non-zero pixels per frame.
module rom_scan_reader #(
  parameter int unsigned IMG_W      = 160,
  parameter int unsigned IMG_H      = 120,
  parameter int unsigned PIXEL_W    = 1,
  parameter int unsigned READ_LAT   = 0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic [2:0]         seg_sel,
  output logic               busy,
  output logic               done,
  output logic [7:0]         rom_yoff,
  output logic [7:0]         rom_xoff,
  output logic [2:0]         rom_select,
  input  logic [PIXEL_W-1:0] rom_pixel,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [PIXEL_W-1:0] pix_data,
  output logic               pix_sof,
  output logic               pix_eol,
  output logic               pix_eof
`ifdef ROM_SCAN_ONES_COUNT_EN
  ,
  output logic [15:0]        ones_count
`endif
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + READ_LAT + 1) + 1;
  localparam logic [7:0]  X_LAST = 8'(IMG_W - 1);
  localparam logic [7:0]  Y_LAST = 8'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } tag_t;

  typedef struct packed {
    logic [PIXEL_W-1:0] data;
    tag_t               tag;
  } entry_t;

  state_t          state;
  state_t          state_nx;

  logic            accept;
  logic            issue;
  logic            last_addr;
  tag_t            issue_tag;

  logic            push;
  tag_t            push_tag;
  logic            pop;
  logic [CW-1:0]   in_flight;
  logic [CW-1:0]   occ;

  entry_t          mem [FIFO_DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Address-side decode: tags of the address currently presented to the ROM.
  always_comb begin
    last_addr     = (rom_xoff == X_LAST) && (rom_yoff == Y_LAST);
    issue_tag.sof = (rom_xoff == 8'd0) && (rom_yoff == 8'd0);
    issue_tag.eol = (rom_xoff == X_LAST);
    issue_tag.eof = (rom_xoff == X_LAST) && (rom_yoff == Y_LAST);
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next state, credit-gated issue and status outputs.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    issue    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = S_SCAN;
        end
      end
      S_SCAN: begin
        busy  = 1'b1;
        issue = ((occ + in_flight) < CW'(FIFO_DEPTH));
        if (issue && last_addr) begin
          state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        // Leave as the final entry is popped so done lands one cycle after it.
        if ((in_flight == '0) && ((occ == '0) || ((occ == CW'(1)) && pop))) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // ROM address generator: raster order, holds when no issue occurs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rom_xoff   <= '0;
      rom_yoff   <= '0;
      rom_select <= '0;
    end else if (accept) begin
      rom_xoff   <= '0;
      rom_yoff   <= '0;
      rom_select <= seg_sel;
    end else if (issue && !last_addr) begin
      if (rom_xoff == X_LAST) begin
        rom_xoff <= '0;
        rom_yoff <= rom_yoff + 8'd1;
      end else begin
        rom_xoff <= rom_xoff + 8'd1;
      end
    end
  end

  generate
    if (READ_LAT == 0) begin : g_comb_rom
      assign push      = issue;
      assign push_tag  = issue_tag;
      assign in_flight = '0;
    end else begin : g_pipe_rom
      logic pv [READ_LAT];
      tag_t pt [READ_LAT];

      // Valid/tag shift register matching the ROM read latency.
      always_ff @(posedge CLK) begin
        if (RST) begin
          for (int unsigned i = 0; i < READ_LAT; i++) begin
            pv[i] <= 1'b0;
          end
        end else begin
          pv[0] <= issue;
          for (int unsigned i = 1; i < READ_LAT; i++) begin
            pv[i] <= pv[i-1];
          end
        end
        pt[0] <= issue_tag;
        for (int unsigned i = 1; i < READ_LAT; i++) begin
          pt[i] <= pt[i-1];
        end
      end

      // Reads issued but not yet pushed into the FIFO.
      always_comb begin
        in_flight = '0;
        for (int unsigned i = 0; i < READ_LAT; i++) begin
          in_flight = in_flight + CW'(pv[i]);
        end
      end

      assign push     = pv[READ_LAT-1];
      assign push_tag = pt[READ_LAT-1];
    end
  endgenerate

  assign pop = pix_valid && pix_ready;

  // FIFO storage; ROM data is captured in the cycle its tags leave the pipe.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= {rom_pixel, push_tag};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      unique case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  // Stream outputs, forced to zero while the FIFO is empty.
  always_comb begin
    pix_valid = (occ != '0);
    pix_data  = '0;
    pix_sof   = 1'b0;
    pix_eol   = 1'b0;
    pix_eof   = 1'b0;
    if (pix_valid) begin
      pix_data = head.data;
      pix_sof  = head.tag.sof;
      pix_eol  = head.tag.eol;
      pix_eof  = head.tag.eof;
    end
  end

`ifdef ROM_SCAN_ONES_COUNT_EN
  // Saturating count of non-zero pixels handed off in the current frame.
  always_ff @(posedge CLK) begin
    if (RST || accept) begin
      ones_count <= '0;
    end else if (pop && (pix_data != '0) && (ones_count != 16'hFFFF)) begin
      ones_count <= ones_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rom_scan_reader.sv
// Self-checking bench for rom_scan_reader: four instances with different
// geometry and ROM latency run the same directed frame sequence side by side.
module tb_rom_scan_reader;

  localparam int NI = 4;
  localparam int PW = 4;
  localparam int unsigned IW [NI] = '{4, 3, 1, 1};
  localparam int unsigned IH [NI] = '{2, 3, 2, 1};
  localparam int unsigned IL [NI] = '{0, 2, 1, 3};

  logic          CLK;
  logic          RST;
  logic          start      [NI];
  logic [2:0]    seg_sel    [NI];
  logic          busy       [NI];
  logic          done       [NI];
  logic [7:0]    rom_yoff   [NI];
  logic [7:0]    rom_xoff   [NI];
  logic [2:0]    rom_select [NI];
  logic [PW-1:0] rom_pixel  [NI];
  logic          pix_valid  [NI];
  logic          pix_ready  [NI];
  logic [PW-1:0] pix_data   [NI];
  logic          pix_sof    [NI];
  logic          pix_eol    [NI];
  logic          pix_eof    [NI];
`ifdef ROM_SCAN_ONES_COUNT_EN
  logic [15:0]   ones_count [NI];
`endif

  logic [31:0] frame_seed;
  int n_tests = 0;
  int n_fail  = 0;

  // ROM contents: segment 5 holds ones at the first five raster positions of a
  // 4-wide image, every other segment holds hashed pseudo-random pixels.
  function automatic logic [PW-1:0] rom_val(input logic [31:0] seed, input logic [2:0] seg,
                                            input logic [7:0] y, input logic [7:0] x);
    logic [31:0] h;
    if (seg == 3'd5) return ((32'(x) + 32'(y) * 4) < 5) ? PW'(1) : '0;
    h = seed ^ (32'(seg) * 32'h9E3779B1) ^ (32'(y) * 32'h85EBCA6B) ^ (32'(x) * 32'hC2B2AE35);
    h = h ^ (h >> 15);
    h = h * 32'h2C1B3C6D;
    h = h ^ (h >> 12);
    return h[PW-1:0];
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    rom_scan_reader #(
      .IMG_W(IW[g]), .IMG_H(IH[g]), .PIXEL_W(PW), .READ_LAT(IL[g]), .FIFO_DEPTH(4)
    ) u_dut (
      .CLK(CLK), .RST(RST), .start(start[g]), .seg_sel(seg_sel[g]),
      .busy(busy[g]), .done(done[g]),
      .rom_yoff(rom_yoff[g]), .rom_xoff(rom_xoff[g]), .rom_select(rom_select[g]),
      .rom_pixel(rom_pixel[g]),
      .pix_valid(pix_valid[g]), .pix_ready(pix_ready[g]), .pix_data(pix_data[g]),
      .pix_sof(pix_sof[g]), .pix_eol(pix_eol[g]), .pix_eof(pix_eof[g])
`ifdef ROM_SCAN_ONES_COUNT_EN
      , .ones_count(ones_count[g])
`endif
    );

    if (IL[g] == 0) begin : g_rom0
      assign rom_pixel[g] = rom_val(frame_seed, rom_select[g], rom_yoff[g], rom_xoff[g]);
    end else begin : g_romn
      logic [7:0] yq [4];
      logic [7:0] xq [4];
      logic [2:0] sq [4];
      always @(posedge CLK) begin
        yq[0] <= rom_yoff[g];
        xq[0] <= rom_xoff[g];
        sq[0] <= rom_select[g];
        for (int k = 1; k < 4; k++) begin
          yq[k] <= yq[k-1];
          xq[k] <= xq[k-1];
          sq[k] <= sq[k-1];
        end
      end
      assign rom_pixel[g] = rom_val(frame_seed, sq[IL[g]-1], yq[IL[g]-1], xq[IL[g]-1]);
    end
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic string tg(input string n, input int g);
    return $sformatf("%s[%0d]", n, g);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_zero(input string ctx);
    for (int g = 0; g < NI; g++) begin
      chk(tg({ctx, "_outputs"}, g),
          {3'b0, busy[g], done[g], pix_valid[g], pix_data[g], pix_sof[g], pix_eol[g], pix_eof[g],
           rom_yoff[g], rom_xoff[g], rom_select[g]}, 32'd0);
`ifdef ROM_SCAN_ONES_COUNT_EN
      chk(tg({ctx, "_ones"}, g), 32'(ones_count[g]), 32'd0);
`endif
    end
  endtask

  // mode 0: ready always 1, 1: ready pattern 1-0-0-1, 2: random ready.
  // abort_after > 0: reset once instance 0 has made that many handoffs.
  // poke: extra start pulses (seg 3'b011) mid-frame and in each done cycle.
  task automatic run_frame(input logic [2:0] seg, input int mode, input int abort_after, input bit poke);
    int idx [NI];
    int ones [NI];
    bit fin [NI];
    bit dexp [NI];
    bit stall [NI];
    logic [31:0] held [NI];
    int cyc;
    int n;
    bit all_fin;
    bit r;
    int ex;
    logic [PW-1:0] ed;
    logic [31:0] etup;
    logic [31:0] gtup;

    frame_seed = $urandom;
    for (int g = 0; g < NI; g++) begin
      idx[g] = 0; ones[g] = 0; fin[g] = 0; dexp[g] = 0; stall[g] = 0; held[g] = '0;
      start[g] = 1'b1; seg_sel[g] = seg; pix_ready[g] = 1'b1;
    end
    step();
    cyc = 1;
    all_fin = 0;
    while (1) begin
      for (int g = 0; g < NI; g++) begin
        start[g] = 1'b0;
        seg_sel[g] = 3'($urandom_range(0, 7));
      end
      all_fin = 1;
      for (int g = 0; g < NI; g++) begin
        n = int'(IW[g] * IH[g]);
        if (fin[g]) begin
          chk(tg("idle_busy", g), 32'(busy[g]), 32'd0);
          chk(tg("idle_done", g), 32'(done[g]), 32'd0);
`ifdef ROM_SCAN_ONES_COUNT_EN
          chk(tg("ones_hold", g), 32'(ones_count[g]), 32'(ones[g]));
`endif
        end else if (dexp[g]) begin
          chk(tg("done_pulse", g), 32'(done[g]), 32'd1);
          chk(tg("busy_drop", g), 32'(busy[g]), 32'd0);
          chk(tg("no_extra_valid", g), 32'(pix_valid[g]), 32'd0);
`ifdef ROM_SCAN_ONES_COUNT_EN
          chk(tg("ones_final", g), 32'(ones_count[g]), 32'(ones[g]));
          if (seg == 3'd5 && g == 0) chk("ones_seg5", 32'(ones_count[g]), 32'd5);
`endif
          fin[g] = 1;
          if (poke) begin
            start[g] = 1'b1;
            seg_sel[g] = 3'b011;
          end
        end else begin
          chk(tg("done_low", g), 32'(done[g]), 32'd0);
          chk(tg("busy_high", g), 32'(busy[g]), 32'd1);
          chk(tg("rom_select", g), 32'(rom_select[g]), 32'(seg));
`ifdef ROM_SCAN_ONES_COUNT_EN
          chk(tg("ones_run", g), 32'(ones_count[g]), 32'(ones[g]));
`endif
          gtup = {25'd0, pix_data[g], pix_sof[g], pix_eol[g], pix_eof[g]};
          if (stall[g]) begin
            chk(tg("stall_valid", g), 32'(pix_valid[g]), 32'd1);
            chk(tg("stall_data", g), gtup, held[g]);
          end
          if (mode == 0) begin
            r = 1'b1;
            chk(tg("valid_timing", g), 32'(pix_valid[g]),
                32'((cyc >= int'(IL[g]) + 2) && (cyc < int'(IL[g]) + 2 + n)));
          end else if (mode == 1) begin
            r = ((cyc % 4) == 0) || ((cyc % 4) == 3);
          end else begin
            r = 1'($urandom_range(0, 1));
          end
          pix_ready[g] = r;
          if (pix_valid[g] && r) begin
            ex = idx[g] % int'(IW[g]);
            ed = rom_val(frame_seed, seg, 8'(idx[g] / int'(IW[g])), 8'(ex));
            etup = {25'd0, ed, idx[g] == 0, ex == int'(IW[g]) - 1, idx[g] == n - 1};
            chk(tg($sformatf("pixel%0d", idx[g]), g), gtup, etup);
            if (ed != '0) ones[g]++;
            idx[g]++;
            if (idx[g] == n) dexp[g] = 1;
            stall[g] = 0;
          end else begin
            stall[g] = pix_valid[g];
            held[g] = gtup;
          end
          if (poke && cyc == 3) begin
            start[g] = 1'b1;
            seg_sel[g] = 3'b011;
          end
        end
        all_fin &= fin[g];
      end
      if (abort_after > 0 && idx[0] == abort_after) begin
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk_zero("abort");
        step();
        for (int g = 0; g < NI; g++) begin
          chk(tg("abort_no_done", g), 32'(done[g]), 32'd0);
          chk(tg("abort_busy", g), 32'(busy[g]), 32'd0);
        end
        return;
      end
      if (all_fin || cyc >= 400) break;
      step();
      cyc++;
    end
    chk("frame_complete", 32'(all_fin), 32'd1);
    step();
    for (int g = 0; g < NI; g++) begin
      start[g] = 1'b0;
      chk(tg("post_busy", g), 32'(busy[g]), 32'd0);
      chk(tg("post_done", g), 32'(done[g]), 32'd0);
    end
  endtask

  initial begin
    frame_seed = 32'h1234_5678;
    RST = 1'b1;
    for (int g = 0; g < NI; g++) begin
      start[g] = 1'b1;
      seg_sel[g] = 3'b111;
      pix_ready[g] = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      step();
      chk_zero($sformatf("reset%0d", i));
    end
    RST = 1'b0;
    for (int g = 0; g < NI; g++) start[g] = 1'b0;
    step();
    chk_zero("idle");

    run_frame(3'b001, 0, 0, 1'b0);
    run_frame(3'($urandom_range(0, 7)), 1, 0, 1'b0);
    run_frame(3'b110, 2, 0, 1'b1);
    run_frame(3'b100, 0, 3, 1'b0);
    run_frame(3'b010, 0, 0, 1'b0);
    run_frame(3'b101, 0, 0, 1'b0);
    run_frame(3'b101, 1, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      run_frame(3'($urandom_range(0, 7)), 2, 0, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
